// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux block.
// Optional build macro STREAM_MUX_LOCK_EN is handled in stream_mux.sv.
package stream_mux_pkg;

  localparam int   NUM_IN_MAX = 64;
  localparam logic MODE_SEL   = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels, never narrower than one bit
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Round-robin arbiter: first requester after ptr wins, scanning upward with wrap.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module stream_mux_rr_arb
  import stream_mux_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      c = (int'(ptr) + k) % NUM_IN;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
    any = found;
  end

endmodule

// File: rtl/stream_mux.sv
// Registered N:1 stream multiplexer, explicit-select or round-robin per beat.
// Build macro STREAM_MUX_LOCK_EN adds in_last/out_last and packet-level grant locking.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sel_mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef STREAM_MUX_LOCK_EN
  ,
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_last
`endif
);

  localparam logic [SEL_W:0] NUM_IN_X = (SEL_W+1)'(NUM_IN);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              sel_err_q, sel_err_d;
`ifdef STREAM_MUX_LOCK_EN
  logic              lock_q, lock_d;
  logic              out_last_q, out_last_d;
`endif

  logic              load, xfer, sel_oor, any_gnt;
  logic [NUM_IN-1:0] grant, rr_grant;
  logic [SEL_W-1:0]  gnt_idx, rr_idx;
  logic              rr_any;

  stream_mux_rr_arb #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arb (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Grant source: held packet channel, else round-robin, else explicit select
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sel_oor = ({1'b0, sel} >= NUM_IN_X);
`ifdef STREAM_MUX_LOCK_EN
    if (lock_q) begin
      gnt_idx           = out_src_q;
      any_gnt           = in_valid[out_src_q];
      grant[out_src_q]  = in_valid[out_src_q];
    end else
`endif
    if (sel_mode == MODE_RR) begin
      grant   = rr_grant;
      gnt_idx = rr_idx;
      any_gnt = rr_any;
    end else if (!sel_oor) begin
      gnt_idx    = sel;
      any_gnt    = in_valid[sel];
      grant[sel] = in_valid[sel];
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign xfer     = any_gnt && load;
  assign in_ready = grant & {NUM_IN{load}};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    sel_err_d   = (sel_mode == MODE_SEL) && sel_oor;
`ifdef STREAM_MUX_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_src_d  = gnt_idx;
`ifdef STREAM_MUX_LOCK_EN
      // The pointer moves only when a packet completes so fairness is per packet
      lock_d     = !in_last[gnt_idx];
      out_last_d = in_last[gnt_idx];
      if (sel_mode == MODE_RR && in_last[gnt_idx]) rr_ptr_d = gnt_idx;
`else
      if (sel_mode == MODE_RR) rr_ptr_d = gnt_idx;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
      sel_err_q   <= 1'b0;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel_err   = sel_err_q;
`ifdef STREAM_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: a 16-channel instance checked against a transaction-level
// model, plus a 12-channel instance for out-of-range select handling.
module tb_stream_mux;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int SW  = 4;
  localparam int NB  = 12;
  localparam int SWB = 4;
`ifdef STREAM_MUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          sel_mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_ready;
  logic          sel_err;
  logic [N-1:0]  in_last;
  logic          out_last;

  logic           sel_mode_b;
  logic [SWB-1:0] sel_b;
  logic [NB-1:0]  in_valid_b;
  logic [NB*W-1:0] in_data_b;
  logic [NB-1:0]  in_ready_b;
  logic           out_valid_b;
  logic [W-1:0]   out_data_b;
  logic [SWB-1:0] out_src_b;
  logic           out_ready_b;
  logic           sel_err_b;
  logic [NB-1:0]  in_last_b;
  logic           out_last_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the output register should hold, and the fairness pointer
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;
  logic         m_lock;
  logic         m_last;

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .reset(rst_n), .sel_mode(sel_mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel_err(sel_err)
`ifdef STREAM_MUX_LOCK_EN
    , .in_last(in_last), .out_last(out_last)
`endif
  );

  stream_mux #(.WIDTH(W), .NUM_IN(NB)) dut_b (
    .clk(clk), .reset(rst_n), .sel_mode(sel_mode_b), .sel(sel_b),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_src(out_src_b),
    .out_ready(out_ready_b), .sel_err(sel_err_b)
`ifdef STREAM_MUX_LOCK_EN
    , .in_last(in_last_b), .out_last(out_last_b)
`endif
  );

`ifndef STREAM_MUX_LOCK_EN
  assign out_last   = 1'b0;
  assign out_last_b = 1'b0;
`endif

  function automatic int model_pick();
    if (LOCK && m_lock) return in_valid[m_src] ? m_src : -1;
    if (sel_mode) begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_ptr + k) % N;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (int'(sel) < N && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r = '0;
    int g = model_pick();
    if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_commit();
    int g = model_pick();
    if (!m_valid || out_ready) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = in_data[g*W +: W];
        m_src  = g;
        m_last = in_last[g];
        if (LOCK) m_lock = !in_last[g];
        if (sel_mode && (!LOCK || in_last[g])) m_ptr = g;
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = N - 1; m_lock = 1'b0; m_last = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  task automatic test_reset();
    sel_mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1; in_last = '1;
    sel_mode_b = 1'b0; sel_b = '0; in_valid_b = '0; out_ready_b = 1'b1; in_last_b = '1;
    in_data = '0; in_data_b = '0;
    rst_n = 1'b0;
    model_reset();
    #3;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || sel_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h src=%0d err=%b, want all 0", out_valid, out_data, out_src, sel_err);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== '0 || out_data !== '0) begin
        miscompares++;
        $display("FAIL idle cyc%0d: valid=%b ready=%h data=%h, want 0/0/0", i, out_valid, in_ready, out_data);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_mode0_fixed();
    sel_mode = 1'b0; sel = 4'd5; in_valid = 16'h0020; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      in_data[5*W +: W] = 32'hCAFE0005;
      #1;
      vectors++;
      if (in_ready !== 16'h0020) begin
        miscompares++;
        $display("FAIL mode0_ready cyc%0d: got %h want 0020", i, in_ready);
      end
      @(posedge clk); model_commit(); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'hCAFE0005 || out_src !== 4'd5) begin
        miscompares++;
        $display("FAIL mode0_out cyc%0d: valid=%b data=%h src=%0d want 1/cafe0005/5", i, out_valid, out_data, out_src);
      end
    end
  endtask

  task automatic test_rr_sweep();
    logic [W-1:0] held;
    logic [N-1:0] exp_rdy;
    sel_mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      rand_data();
      #1;
      exp_rdy = '0; exp_rdy[i % N] = 1'b1;
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_ready beat%0d: got %h want %h", i, in_ready, exp_rdy);
      end
      @(posedge clk); model_commit(); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_src !== SW'(i % N) || out_data !== m_data) begin
        miscompares++;
        $display("FAIL rr_out beat%0d: src=%0d data=%h want src=%0d data=%h", i, out_src, out_data, i % N, m_data);
      end
    end
    held = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      #1;
      vectors++;
      if (in_ready !== '0 || out_data !== held || out_valid !== 1'b1 || out_src !== 4'd0) begin
        miscompares++;
        $display("FAIL rr_stall cyc%0d: ready=%h data=%h src=%0d want 0/%h/0", i, in_ready, out_data, out_src, held);
      end
      @(posedge clk); model_commit(); #1;
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 16'h0002) begin
      miscompares++;
      $display("FAIL rr_resume: got %h want 0002", in_ready);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < 400; i++) begin
      rand_data();
      sel_mode  = $urandom_range(0, 3) != 0;
      sel       = SW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom) & N'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      in_last   = LOCK ? N'($urandom) : '1;
      #1;
      exp_rdy = model_ready();
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_ready cyc%0d: got %h want %h", i, in_ready, exp_rdy);
      end
      vectors++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_src !== SW'(m_src))) ||
          sel_err !== 1'b0 || (LOCK && m_valid && out_last !== m_last)) begin
        miscompares++;
        $display("FAIL rand_out cyc%0d: v=%b d=%h s=%0d l=%b e=%b want v=%b d=%h s=%0d l=%b e=0",
                 i, out_valid, out_data, out_src, out_last, sel_err, m_valid, m_data, m_src, m_last);
      end
      @(posedge clk); model_commit(); #1;
    end
    in_last = '1;
  endtask

  task automatic test_sel_err();
    logic [NB-1:0] exp_rdy;
    logic          prev_oor;
    sel_mode_b = 1'b0; in_valid_b = '1; out_ready_b = 1'b1; sel_b = 4'd13;
    #1;
    vectors++;
    if (in_ready_b !== '0 || sel_err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_ready: ready=%h err=%b want 000/0", in_ready_b, sel_err_b);
    end
    @(posedge clk); #1;
    vectors++;
    if (sel_err_b !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_err: got %b want 1", sel_err_b);
    end
    sel_b = 4'd3;
    #1;
    vectors++;
    if (in_ready_b !== 12'h008) begin
      miscompares++;
      $display("FAIL oor_recover_ready: got %h want 008", in_ready_b);
    end
    @(posedge clk); #1;
    vectors++;
    if (sel_err_b !== 1'b0 || out_valid_b !== 1'b1 || out_src_b !== 4'd3) begin
      miscompares++;
      $display("FAIL oor_recover_out: err=%b valid=%b src=%0d want 0/1/3", sel_err_b, out_valid_b, out_src_b);
    end
    prev_oor = 1'b0;
    for (int i = 0; i < 24; i++) begin
      sel_b = SWB'($urandom_range(0, 15));
      in_valid_b = NB'($urandom);
      #1;
      exp_rdy = '0;
      if (int'(sel_b) < NB) exp_rdy[sel_b] = in_valid_b[sel_b];
      vectors++;
      if (in_ready_b !== exp_rdy || sel_err_b !== prev_oor) begin
        miscompares++;
        $display("FAIL oor_rand cyc%0d: ready=%h err=%b want %h/%b", i, in_ready_b, sel_err_b, exp_rdy, prev_oor);
      end
      prev_oor = int'(sel_b) >= NB;
      @(posedge clk); #1;
    end
    sel_b = '0; in_valid_b = '0;
  endtask

  task automatic test_reset_mid();
    sel_mode = 1'b0; sel = 4'd7; in_valid = 16'h0080; out_ready = 1'b0;
    rand_data();
    @(posedge clk); model_commit(); #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL premid_valid: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
      miscompares++;
      $display("FAIL midreset: valid=%b data=%h src=%0d want 0/0/0", out_valid, out_data, out_src);
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    sel_mode = 1'b1; in_valid = '1; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 16'h0001) begin
      miscompares++;
      $display("FAIL postreset_ready: got %h want 0001", in_ready);
    end
    @(posedge clk); model_commit(); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_src !== 4'd0) begin
      miscompares++;
      $display("FAIL postreset_src: valid=%b src=%0d want 1/0", out_valid, out_src);
    end
  endtask

`ifdef STREAM_MUX_LOCK_EN
  task automatic test_lock();
    int ch2_beats = 0;
    int exp_src[4] = '{2, 2, 2, 0};
    sel_mode = 1'b1; out_ready = 1'b1; in_last = '1;
    in_valid = 16'h0002;
    rand_data();
    @(posedge clk); model_commit(); #1;
    in_valid = 16'h0007;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      in_last[2] = (ch2_beats == 2);
      sel = SW'($urandom_range(0, N - 1));
      @(posedge clk); model_commit(); #1;
      if (out_src == 4'd2) ch2_beats++;
      vectors++;
      if (out_src !== SW'(exp_src[i]) || out_data !== m_data ||
          (i < 3 && out_last !== (i == 2))) begin
        miscompares++;
        $display("FAIL lock beat%0d: src=%0d last=%b want src=%0d last=%b", i, out_src, out_last, exp_src[i], i == 2);
      end
    end
    in_last = '1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mode0_fixed();
    test_rr_sweep();
    test_random();
    test_sel_err();
    test_reset_mid();
`ifdef STREAM_MUX_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
